// File: rtl/red_pitaya_dac_slew_pkg.sv
// Shared types and the slew/ramp move rule for the DAC output conditioning stage.
package red_pitaya_dac_slew_pkg;

  localparam int DAC_DW = 14;

  typedef enum logic [1:0] {
    ST_MUTE  = 2'd0,
    ST_UP    = 2'd1,
    ST_TRACK = 2'd2,
    ST_DOWN  = 2'd3
  } slew_st_t;

  // Moves y toward t by at most s; s == 0 jumps straight to t. The result always
  // lies between y and t, so it cannot leave the DAC_DW range.
  function automatic logic signed [DAC_DW-1:0] approach(
    input logic signed [DAC_DW-1:0] y,
    input logic signed [DAC_DW-1:0] t,
    input logic        [DAC_DW-2:0] s
  );
    logic signed [DAC_DW:0] d;
    logic signed [DAC_DW:0] s_wide;
    d      = $signed({t[DAC_DW-1], t}) - $signed({y[DAC_DW-1], y});
    s_wide = $signed({2'b00, s});
    if (s == '0) begin
      return t;
    end else if (d > s_wide) begin
      return y + $signed({1'b0, s});
    end else if (d < -s_wide) begin
      return y - $signed({1'b0, s});
    end
    return t;
  endfunction

endpackage

// File: rtl/red_pitaya_dac_slew_ch.sv
// One DAC channel: enable/mute ramp FSM, slew-rate limiter and status flags.
module red_pitaya_dac_slew_ch
  import red_pitaya_dac_slew_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic signed [DAC_DW-1:0] x_i,
  input  logic                     en_i,
  input  logic        [DAC_DW-2:0] ramp_step_i,
  input  logic        [DAC_DW-2:0] slew_step_i,
  output logic signed [DAC_DW-1:0] y_o,
  output logic                     active_o,
  output logic                     settled_o
);

  slew_st_t                 state_q, state_d;
  logic signed [DAC_DW-1:0] y_q, y_d;
  logic                     active_q, active_d;
  logic                     settled_q, settled_d;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    case (state_q)
      ST_MUTE: begin
        y_d = '0;
        if (en_i) state_d = ST_UP;
      end
      ST_UP: begin
        y_d = approach(y_q, x_i, ramp_step_i);
        if (!en_i)          state_d = ST_DOWN;
        else if (y_d == x_i) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        y_d = approach(y_q, x_i, slew_step_i);
        if (!en_i) state_d = ST_DOWN;
      end
      ST_DOWN: begin
        y_d = approach(y_q, '0, ramp_step_i);
        // A re-enable wins over reaching zero, so a reversal never visits MUTE.
        if (en_i)            state_d = ST_UP;
        else if (y_d == '0)  state_d = ST_MUTE;
      end
      default: begin
        state_d = ST_MUTE;
        y_d     = '0;
      end
    endcase
    active_d  = (state_d != ST_MUTE);
    settled_d = (state_q == ST_TRACK) && (y_d == x_i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_MUTE;
      y_q       <= '0;
      active_q  <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      active_q  <= active_d;
      settled_q <= settled_d;
    end
  end

  assign y_o       = y_q;
  assign active_o  = active_q;
  assign settled_o = settled_q;

endmodule

// File: rtl/red_pitaya_dac_slew.sv
// Two independent DAC conditioning channels between the ASG buffers and the DAC interface.
module red_pitaya_dac_slew
  import red_pitaya_dac_slew_pkg::*;
(
  input  logic                     dac_clk_i,
  input  logic                     dac_rstn_i,
  input  logic signed [DAC_DW-1:0] dac_a_i,
  input  logic signed [DAC_DW-1:0] dac_b_i,
  input  logic                     en_a_i,
  input  logic                     en_b_i,
  input  logic        [DAC_DW-2:0] ramp_step_a_i,
  input  logic        [DAC_DW-2:0] ramp_step_b_i,
  input  logic        [DAC_DW-2:0] slew_step_a_i,
  input  logic        [DAC_DW-2:0] slew_step_b_i,
  output logic signed [DAC_DW-1:0] dac_a_o,
  output logic signed [DAC_DW-1:0] dac_b_o,
  output logic                     active_a_o,
  output logic                     active_b_o,
  output logic                     settled_a_o,
  output logic                     settled_b_o
);

  red_pitaya_dac_slew_ch u_ch_a (
    .clk_i       (dac_clk_i),
    .rst_ni      (dac_rstn_i),
    .x_i         (dac_a_i),
    .en_i        (en_a_i),
    .ramp_step_i (ramp_step_a_i),
    .slew_step_i (slew_step_a_i),
    .y_o         (dac_a_o),
    .active_o    (active_a_o),
    .settled_o   (settled_a_o)
  );

  red_pitaya_dac_slew_ch u_ch_b (
    .clk_i       (dac_clk_i),
    .rst_ni      (dac_rstn_i),
    .x_i         (dac_b_i),
    .en_i        (en_b_i),
    .ramp_step_i (ramp_step_b_i),
    .slew_step_i (slew_step_b_i),
    .y_o         (dac_b_o),
    .active_o    (active_b_o),
    .settled_o   (settled_b_o)
  );

endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Directed bench for red_pitaya_dac_slew: expectations are queued with each stimulus step and checked after the edge.
module tb_red_pitaya_dac_slew;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [13:0] x_a, x_b;
  logic               en_a, en_b;
  logic        [12:0] ramp_a, ramp_b, slew_a, slew_b;
  logic signed [13:0] y_a, y_b;
  logic               act_a, act_b, set_a, set_b;

  red_pitaya_dac_slew dut (
    .dac_clk_i     (clk),
    .dac_rstn_i    (rst_n),
    .dac_a_i       (x_a),
    .dac_b_i       (x_b),
    .en_a_i        (en_a),
    .en_b_i        (en_b),
    .ramp_step_a_i (ramp_a),
    .ramp_step_b_i (ramp_b),
    .slew_step_a_i (slew_a),
    .slew_step_b_i (slew_b),
    .dac_a_o       (y_a),
    .dac_b_o       (y_b),
    .active_a_o    (act_a),
    .active_b_o    (act_b),
    .settled_a_o   (set_a),
    .settled_b_o   (set_b)
  );

  always #4 clk = ~clk;

  typedef struct {
    string tag;
    int    sig;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic signed [31:0] actual(input int sig);
    case (sig)
      0:       return 32'(y_a);
      1:       return {31'b0, act_a};
      2:       return {31'b0, set_a};
      3:       return 32'(y_b);
      4:       return {31'b0, act_b};
      default: return {31'b0, set_b};
    endcase
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sig, input int exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // settled < 0 means "not checked at this step".
  task automatic push_a(input string tag, input int y, input int act, input int settled);
    push({tag, ".y_a"}, 0, y);
    push({tag, ".act_a"}, 1, act);
    if (settled >= 0) push({tag, ".set_a"}, 2, settled);
  endtask

  task automatic push_b(input string tag, input int y, input int act, input int settled);
    push({tag, ".y_b"}, 3, y);
    push({tag, ".act_b"}, 4, act);
    if (settled >= 0) push({tag, ".set_b"}, 5, settled);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, actual(e.sig), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    x_a    = 14'sd5000;
    x_b    = '0;
    ramp_a = '0;
    ramp_b = '0;
    slew_a = '0;
    slew_b = '0;

    // Reset and idle
    #20;
    push_a("rst", 0, 0, 0);
    push_b("rst", 0, 0, 0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_a("idle", 0, 0, 0);
    cyc();

    // Ramp up to 8000 in 1000 steps
    x_a    = 14'sd8000;
    ramp_a = 13'd1000;
    en_a   = 1'b1;
    push_a("up_start", 0, 1, 0);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      push_a("ramp_up", 1000 * i, 1, 0);
      cyc();
    end
    push_a("up_settled", 8000, 1, 1);
    cyc();

    // Ramp down from -8000 with reversal before reaching zero
    x_a = -14'sd8000;
    push_a("trk_neg", -8000, 1, 1);
    cyc();
    ramp_a = 13'd3000;
    en_a   = 1'b0;
    push_a("dn_enter", -8000, 1, -1);
    cyc();
    push_a("dn1", -5000, 1, 0);
    cyc();
    push_a("dn2", -2000, 1, 0);
    cyc();
    en_a = 1'b1;
    push_a("rev", 0, 1, 0);
    cyc();
    push_a("rev_up1", -3000, 1, 0);
    cyc();
    push_a("rev_up2", -6000, 1, 0);
    cyc();
    push_a("rev_up3", -8000, 1, 0);
    cyc();
    push_a("rev_trk", -8000, 1, 1);
    cyc();

    // Slew limit 100 per cycle, 0 -> 8000
    x_a = '0;
    push_a("slew_pre", 0, 1, 1);
    cyc();
    slew_a = 13'd100;
    x_a    = 14'sd8000;
    for (int i = 1; i <= 80; i++) begin
      push_a("slew", 100 * i, 1, (i == 80) ? 1 : 0);
      cyc();
    end

    // Extremes: unlimited slew between full-scale codes
    slew_a = '0;
    for (int i = 0; i < 4; i++) begin
      x_a = (i % 2 == 1) ? -14'sd8192 : 14'sd8191;
      push_a("ext_alt", (i % 2 == 1) ? -8192 : 8191, 1, 1);
      cyc();
    end
    ramp_a = 13'd8191;
    en_a   = 1'b0;
    push_a("ext_dn0", -8192, 1, -1);
    cyc();
    push_a("ext_dn1", -1, 1, 0);
    cyc();
    push_a("ext_mute", 0, 0, 0);
    cyc();
    en_a = 1'b1;
    push_a("ext_up0", 0, 1, 0);
    cyc();
    push_a("ext_up1", -8191, 1, 0);
    cyc();
    push_a("ext_up2", -8192, 1, 0);
    cyc();
    push_a("ext_trk", -8192, 1, 1);
    cyc();

    // Asynchronous reset in the middle of a ramp
    ramp_a = '0;
    en_a   = 1'b0;
    push_a("m_dn", -8192, 1, -1);
    cyc();
    push_a("m_mute", 0, 0, 0);
    cyc();
    x_a    = 14'sd5000;
    ramp_a = 13'd400;
    en_a   = 1'b1;
    push_a("m_up0", 0, 1, 0);
    cyc();
    for (int i = 1; i <= 3; i++) begin
      push_a("m_up", 400 * i, 1, 0);
      cyc();
    end
    #2;
    rst_n = 1'b0;
    #1;
    push_a("async_rst", 0, 0, 0);
    drain();
    #2;
    rst_n = 1'b1;
    push_a("post_rst", 0, 1, 0);
    cyc();

    // Channel independence: A ramps while B toggles enable with instant ramp
    x_b    = 14'sd3000;
    ramp_b = '0;
    for (int k = 1; k <= 6; k++) begin
      en_b = (k % 2 == 1);
      push_a("ind_a", 400 * k, 1, 0);
      push_b("ind_b", (k == 1) ? 0 : ((k % 2 == 0) ? 3000 : 0), 1, 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
